branch_predictor: RTL and testbench

Dynamic branch predictor and resolution checker that closes the loop with the execute-stage branch comparator. At fetch it looks up a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and supplies a predicted direction and target. At execute it consumes the resolved branch decision (the comparator's taken/not-taken select), trains the table, and raises a registered mispredict/redirect to the fetch unit.

---
 rtl/branch_predictor_pkg.sv | 22 ++
 rtl/branch_predictor_sat_counter.sv | 25 ++
 rtl/branch_predictor.sv | 121 ++++++++++++
 tb/tb_branch_predictor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor slice.
// Holds the default address width, the 2-bit counter encodings and the
// helper that sizes the BTB tag field.
package branch_predictor_pkg;

  localparam int XLEN  = 32;
  localparam int CTR_W = 2;

  // Saturating counter states: strongly/weakly not-taken, weakly/strongly taken.
  typedef enum logic [CTR_W-1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Tag covers everything above the index and the two ignored byte bits.
  function automatic int tag_width(input int xlen, input int idx_w);
    return xlen - idx_w - 2;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// bp_sat_counter: next-state function of a 2-bit saturating up/down counter.
// Ports:
//   ctr      - current counter state
//   up       - 1 = count toward ST (taken), 0 = count toward SNT (not taken)
//   ctr_next - next counter state, saturating at SNT and ST
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  ctr_t ctr,
  input  logic up,
  output ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    case (ctr)
      SNT:     ctr_next = up ? WNT : SNT;
      WNT:     ctr_next = up ? WT  : SNT;
      WT:      ctr_next = up ? ST  : WNT;
      ST:      ctr_next = up ? ST  : WT;
      default: ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters plus resolution check.
// Ports:
//   clk, reset                - clock, asynchronous active-high reset
//   fetch_pc                  - PC being fetched (lookup is combinational)
//   predict_hit/taken/target  - prediction for fetch_pc
//   resolve_*                 - outcome of a branch resolving in execute, with
//                               the prediction that travelled alongside it
//   mispredict, redirect_pc   - registered one-cycle redirect request
//   mispredict_count          - saturating mispredict counter
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN    = branch_predictor_pkg::XLEN,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            predict_hit,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_target,
  input  logic            resolve_valid,
  input  logic [XLEN-1:0] resolve_pc,
  input  logic            resolve_taken,
  input  logic [XLEN-1:0] resolve_target,
  input  logic            resolve_pred_taken,
  input  logic [XLEN-1:0] resolve_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     mispredict_count
);

  localparam int TAG_W = tag_width(XLEN, IDX_W);

  // Table lives in flops so reset can clear every entry at once.
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [XLEN-1:0]    targets [ENTRIES];
  ctr_t               ctrs    [ENTRIES];

  // ---------------- fetch-side lookup ----------------
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign fetch_tag = fetch_pc[XLEN-1:IDX_W+2];

  always_comb begin
    predict_hit    = valid[fetch_idx] && (tags[fetch_idx] == fetch_tag);
    predict_taken  = predict_hit && ctrs[fetch_idx][1];
    predict_target = predict_hit ? targets[fetch_idx] : fetch_pc + XLEN'(4);
  end

  // ---------------- resolve-side training ----------------
  logic [IDX_W-1:0] res_idx;
  logic [TAG_W-1:0] res_tag;
  logic             res_hit;
  ctr_t             ctr_next;

  assign res_idx = resolve_pc[IDX_W+1:2];
  assign res_tag = resolve_pc[XLEN-1:IDX_W+2];
  assign res_hit = valid[res_idx] && (tags[res_idx] == res_tag);

  bp_sat_counter u_sat_counter (
    .ctr      (ctrs[res_idx]),
    .up       (resolve_taken),
    .ctr_next (ctr_next)
  );

  // Lookups read the array directly, so a same-cycle update to the same
  // index is only seen after this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tags[i]    <= '0;
        targets[i] <= '0;
        ctrs[i]    <= WNT;
      end
    end else if (resolve_valid) begin
      if (res_hit) begin
        ctrs[res_idx] <= ctr_next;
        if (resolve_taken) targets[res_idx] <= resolve_target;
      end else if (resolve_taken) begin
        // Taken miss overwrites whatever alias occupied the slot.
        valid[res_idx]   <= 1'b1;
        tags[res_idx]    <= res_tag;
        targets[res_idx] <= resolve_target;
        ctrs[res_idx]    <= WT;
      end
    end
  end

  // ---------------- mispredict detection ----------------
  logic            misp_now;
  logic [XLEN-1:0] correct_pc;

  assign misp_now = resolve_valid &&
                    ((resolve_pred_taken != resolve_taken) ||
                     (resolve_taken && (resolve_pred_target != resolve_target)));
  assign correct_pc = resolve_taken ? resolve_target : resolve_pc + XLEN'(4);

  // redirect_pc is only meaningful alongside mispredict, so it changes
  // only on mispredicting cycles and otherwise holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      mispredict_count <= '0;
    end else begin
      mispredict <= misp_now;
      if (misp_now) begin
        redirect_pc <= correct_pc;
        if (mispredict_count != 32'hFFFF_FFFF)
          mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int ENT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        predict_hit, predict_taken;
  logic [31:0] predict_target;
  logic        resolve_valid, resolve_taken, resolve_pred_taken;
  logic [31:0] resolve_pc, resolve_target, resolve_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc, mispredict_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(ENT)) dut (
    .clk                 (clk),
    .reset               (reset),
    .fetch_pc            (fetch_pc),
    .predict_hit         (predict_hit),
    .predict_taken       (predict_taken),
    .predict_target      (predict_target),
    .resolve_valid       (resolve_valid),
    .resolve_pc          (resolve_pc),
    .resolve_taken       (resolve_taken),
    .resolve_target      (resolve_target),
    .resolve_pred_taken  (resolve_pred_taken),
    .resolve_pred_target (resolve_pred_target),
    .mispredict          (mispredict),
    .redirect_pc         (redirect_pc),
    .mispredict_count    (mispredict_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] fpc;
    logic        rv;
    logic [31:0] rpc;
    logic        rt;
    logic [31:0] rtgt;
    logic        rpt;
    logic [31:0] rptgt;
    logic        ehit;
    logic        etaken;
    logic [31:0] etgt;
    logic        emisp;
    logic [31:0] eredir;
    logic [31:0] ecnt;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] fpc, input logic rv, input logic [31:0] rpc,
                              input logic rt, input logic [31:0] rtgt, input logic rpt,
                              input logic [31:0] rptgt, input logic ehit, input logic etaken,
                              input logic [31:0] etgt, input logic emisp,
                              input logic [31:0] eredir, input logic [31:0] ecnt);
    vec_t v;
    v.fpc = fpc; v.rv = rv; v.rpc = rpc; v.rt = rt; v.rtgt = rtgt; v.rpt = rpt;
    v.rptgt = rptgt; v.ehit = ehit; v.etaken = etaken; v.etgt = etgt;
    v.emisp = emisp; v.eredir = eredir; v.ecnt = ecnt;
    return v;
  endfunction

  vec_t vecs [14];

  // ---------------- behavioural reference model ----------------
  // Each slot remembers the full word address it was allocated for; a hit
  // is simply "same word address as the resident branch".
  bit          m_valid [ENT];
  logic [29:0] m_word  [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_ctr   [ENT];
  logic [31:0] m_redir;
  logic [31:0] m_cnt;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[midx(pc)] && (m_word[midx(pc)] == pc[31:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_word[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_redir = '0;
    m_cnt   = '0;
  endtask

  // Applies one resolve to the model and returns the expected mispredict.
  function automatic bit model_resolve(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                                       input logic pt, input logic [31:0] ptgt);
    int  i;
    bit  misp;
    i    = midx(pc);
    misp = (pt != t) || (t && (ptgt != tgt));
    if (misp) begin
      m_redir = t ? tgt : pc + 32'd4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    if (m_hit(pc)) begin
      if (t) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (t) begin
      m_valid[i] = 1; m_word[i] = pc[31:2]; m_tgt[i] = tgt; m_ctr[i] = 2;
    end
    return misp;
  endfunction

  task automatic idle_inputs();
    resolve_valid = 0; resolve_pc = 0; resolve_taken = 0; resolve_target = 0;
    resolve_pred_taken = 0; resolve_pred_target = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("rst_misp", 32'(mispredict), 32'd0);
    chk("rst_redir", redirect_pc, 32'd0);
    chk("rst_cnt", mispredict_count, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_pc();
    // Few tags over a few indices so hits and aliases both happen.
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  initial begin
    bit          hit, misp;
    int          k;
    logic [31:0] tgt;

    reset = 1'b1;
    fetch_pc = 32'h100;
    idle_inputs();
    @(posedge clk);
    #1 do_reset();

    vecs[0]  = mk(32'h100, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 0, 32'h104, 0, 32'h0,   32'd0);
    vecs[1]  = mk(32'h100, 1, 32'h100,      1, 32'h200, 0, 32'h0,   0, 0, 32'h104, 1, 32'h200, 32'd1);
    vecs[2]  = mk(32'h100, 0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 1, 32'h200, 0, 32'h200, 32'd1);
    vecs[3]  = mk(32'h100, 1, 32'h100,      0, 32'h0,   1, 32'h200, 1, 1, 32'h200, 1, 32'h104, 32'd2);
    vecs[4]  = mk(32'h100, 1, 32'h100,      0, 32'h0,   0, 32'h0,   1, 0, 32'h200, 0, 32'h104, 32'd2);
    vecs[5]  = mk(32'h100, 1, 32'h100,      0, 32'h0,   0, 32'h0,   1, 0, 32'h200, 0, 32'h104, 32'd2);
    vecs[6]  = mk(32'h100, 0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 0, 32'h200, 0, 32'h104, 32'd2);
    vecs[7]  = mk(32'h100, 1, 32'h100,      1, 32'h300, 0, 32'h0,   1, 0, 32'h200, 1, 32'h300, 32'd3);
    vecs[8]  = mk(32'h100, 0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 0, 32'h300, 0, 32'h300, 32'd3);
    vecs[9]  = mk(32'h100, 1, 32'h140,      1, 32'h500, 1, 32'h500, 1, 0, 32'h300, 0, 32'h300, 32'd3);
    vecs[10] = mk(32'h100, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 0, 32'h104, 0, 32'h300, 32'd3);
    vecs[11] = mk(32'h140, 0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 1, 32'h500, 0, 32'h300, 32'd3);
    vecs[12] = mk(32'h0,   1, 32'hFFFFFFFC, 0, 32'h0,   1, 32'h0,   0, 0, 32'h4,   1, 32'h0,   32'd4);
    vecs[13] = mk(32'hFFFFFFFC, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   32'd4);

    foreach (vecs[i]) begin
      fetch_pc            = vecs[i].fpc;
      resolve_valid       = vecs[i].rv;
      resolve_pc          = vecs[i].rpc;
      resolve_taken       = vecs[i].rt;
      resolve_target      = vecs[i].rtgt;
      resolve_pred_taken  = vecs[i].rpt;
      resolve_pred_target = vecs[i].rptgt;
      @(negedge clk);
      chk($sformatf("vec%0d_hit", i),   32'(predict_hit),   32'(vecs[i].ehit));
      chk($sformatf("vec%0d_taken", i), 32'(predict_taken), 32'(vecs[i].etaken));
      chk($sformatf("vec%0d_tgt", i),   predict_target,     vecs[i].etgt);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_misp", i),  32'(mispredict),    32'(vecs[i].emisp));
      chk($sformatf("vec%0d_redir", i), redirect_pc,        vecs[i].eredir);
      chk($sformatf("vec%0d_cnt", i),   mispredict_count,   vecs[i].ecnt);
      $display("[TB] vec %0d fetch=%h rv=%0b rpc=%h rt=%0b -> hit=%0b tgt=%h misp=%0b redir=%h cnt=%0d",
               i, vecs[i].fpc, vecs[i].rv, vecs[i].rpc, vecs[i].rt,
               predict_hit, predict_target, mispredict, redirect_pc, mispredict_count);
      idle_inputs();
    end

    // ---------------- randomized phase against the model ----------------
    do_reset();
    model_reset();
    for (int n = 0; n < 250; n++) begin
      fetch_pc       = rand_pc();
      resolve_valid  = ($urandom_range(0, 3) != 0);
      resolve_pc     = rand_pc();
      resolve_taken  = 1'($urandom_range(0, 1));
      resolve_target = 32'($urandom_range(0, 7)) << 8;
      k = midx(resolve_pc);
      if ($urandom_range(0, 1) == 1) begin
        // Carry the prediction the front end would actually have made.
        resolve_pred_taken  = m_hit(resolve_pc) && (m_ctr[k] >= 2);
        resolve_pred_target = m_hit(resolve_pc) ? m_tgt[k] : resolve_pc + 32'd4;
      end else begin
        resolve_pred_taken  = 1'($urandom_range(0, 1));
        resolve_pred_target = 32'($urandom_range(0, 7)) << 8;
      end

      hit = m_hit(fetch_pc);
      tgt = hit ? m_tgt[midx(fetch_pc)] : fetch_pc + 32'd4;
      @(negedge clk);
      chk("rnd_hit",   32'(predict_hit),   32'(hit));
      chk("rnd_taken", 32'(predict_taken), 32'(hit && (m_ctr[midx(fetch_pc)] >= 2)));
      chk("rnd_tgt",   predict_target,     tgt);

      misp = 0;
      if (resolve_valid)
        misp = model_resolve(resolve_pc, resolve_taken, resolve_target,
                             resolve_pred_taken, resolve_pred_target);
      @(posedge clk);
      #1;
      chk("rnd_misp",  32'(mispredict), 32'(misp));
      chk("rnd_redir", redirect_pc,     m_redir);
      chk("rnd_cnt",   mispredict_count, m_cnt);
      $display("[TB] rnd %0d fetch=%h hit=%0b rv=%0b rpc=%h rt=%0b misp=%0b redir=%h cnt=%0d",
               n, fetch_pc, predict_hit, resolve_valid, resolve_pc, resolve_taken,
               mispredict, redirect_pc, mispredict_count);
    end

    // ---------------- reset in the middle of a mispredicting update ----------------
    fetch_pc            = 32'h180;
    resolve_valid       = 1;
    resolve_pc          = 32'h180;
    resolve_taken       = 1;
    resolve_target      = 32'h900;
    resolve_pred_taken  = 0;
    resolve_pred_target = 32'h0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_misp",  32'(mispredict), 32'd0);
    chk("midrst_redir", redirect_pc,     32'd0);
    chk("midrst_cnt",   mispredict_count, 32'd0);
    chk("midrst_hit",   32'(predict_hit), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("midrst_lookup_hit", 32'(predict_hit), 32'd0);
    chk("midrst_lookup_tgt", predict_target,   32'h184);
    @(posedge clk);
    #1;
    chk("midrst_after_misp", 32'(mispredict),  32'd0);
    chk("midrst_after_cnt",  mispredict_count, 32'd0);
    $display("[TB] midreset fetch=%h hit=%0b tgt=%h misp=%0b cnt=%0d",
             fetch_pc, predict_hit, predict_target, mispredict, mispredict_count);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
